// File: rtl/rf_safety_pkg.sv
// ---------------------------------------------------------------------------
// rf_safety_pkg
// Shared definitions for the RF shutdown path: FSM state encoding, state
// width and the default ramp constants that the register map also uses.
// ---------------------------------------------------------------------------
package rf_safety_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN     = 2'd0,
      ST_RAMP    = 2'd1,
      ST_SAFE    = 2'd2,
      ST_RECOVER = 2'd3
   } rf_state_e;

   localparam int DEF_AMP_W            = 16;
   localparam int DEF_RAMP_STEP        = 256;
   localparam int DEF_STEP_DIV         = 16;
   localparam int DEF_CNT_W            = 8;
   localparam int DEF_WARN_ATTEN_SHIFT = 1;

   // Divider counter width; a divide-by-1 still needs a 1-bit counter.
   function automatic int div_cnt_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/rf_shutdown_sequencer_ramp_stepper.sv
// ---------------------------------------------------------------------------
// ramp_stepper
// Holds the amplitude register and the STEP_DIV cycle divider. While enabled
// it steps the value once every STEP_DIV cycles, either down towards zero
// (saturating) or up towards a target (clamped, computed one bit wider so it
// never wraps). A direct load overrides stepping.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   i_clr         clear the divider (step phase restarts)
//   i_en          advance the divider / allow stepping
//   i_dir         1 = step up towards i_target, 0 = step down towards 0
//   i_load        load i_load_val into the value register
//   i_load_val    value to load
//   i_target      upper clamp / completion target for up-steps
//   o_value       current amplitude value (registered)
//   o_step        strobe: a step is applied on this edge
//   o_at_target   up: value >= target; down: value == 0
// ---------------------------------------------------------------------------
module ramp_stepper
   import rf_safety_pkg::*;
#(
   parameter int AMP_W     = DEF_AMP_W,
   parameter int RAMP_STEP = DEF_RAMP_STEP,
   parameter int STEP_DIV  = DEF_STEP_DIV
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic             i_load,
   input  logic [AMP_W-1:0] i_load_val,
   input  logic [AMP_W-1:0] i_target,
   output logic [AMP_W-1:0] o_value,
   output logic             o_step,
   output logic             o_at_target
);

   generate
      if (RAMP_STEP <= 0) begin : g_bad_step
         $error("ramp_stepper: RAMP_STEP must be greater than zero");
      end
      if (STEP_DIV < 1) begin : g_bad_div
         $error("ramp_stepper: STEP_DIV must be at least one");
      end
   endgenerate

   localparam int               DIV_W    = div_cnt_w(STEP_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
   localparam logic [AMP_W:0]   STEP_EXT = (AMP_W + 1)'(RAMP_STEP);
   localparam logic [AMP_W-1:0] STEP_LO  = STEP_EXT[AMP_W-1:0];

   logic [DIV_W-1:0] r_div;
   logic [AMP_W-1:0] r_value;
   logic             w_step;
   logic [AMP_W:0]   w_sum;
   logic [AMP_W-1:0] w_up;
   logic [AMP_W-1:0] w_down;
   logic             w_gt_step;

   assign w_step = i_en & ~i_clr & (r_div == DIV_LAST);

   always_comb begin
      w_sum     = {1'b0, r_value} + STEP_EXT;
      w_up      = (w_sum > {1'b0, i_target}) ? i_target : w_sum[AMP_W-1:0];
      // When the step exceeds the value the result pins at zero; the low
      // slice of the step is only used when the value is strictly larger.
      w_gt_step = ({1'b0, r_value} > STEP_EXT);
      w_down    = w_gt_step ? (r_value - STEP_LO) : '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_div   <= '0;
         r_value <= '0;
      end else begin
         if (i_clr) begin
            r_div <= '0;
         end else if (i_en) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
         end

         if (i_load) begin
            r_value <= i_load_val;
         end else if (w_step) begin
            r_value <= i_dir ? w_up : w_down;
         end
      end
   end

   assign o_value     = r_value;
   assign o_step      = w_step;
   assign o_at_target = i_dir ? (r_value >= i_target) : (r_value == '0);

endmodule

// File: rtl/rf_shutdown_sequencer.sv
// ---------------------------------------------------------------------------
// rf_shutdown_sequencer
// Governs the AM carrier amplitude downstream of the watchdog. A watchdog
// trip ramps the amplitude down to zero, then drops RF enable and latches
// the fault. Recovery needs a rearm while the watchdog is clear, followed by
// a soft ramp-up to the requested amplitude.
//
// Optional build macro: RF_SHUTDOWN_WARN_ATTEN_EN
//   defined   - in RUN with warning_i=1, amplitude is amp_i >> WARN_ATTEN_SHIFT
//   undefined - warning_i is ignored
//
// Ports:
//   clk              system clock
//   rstn             asynchronous active-low reset
//   triggered_i      watchdog triggered level
//   warning_i        watchdog warning level
//   rearm_i          single-cycle rearm request
//   amp_i            requested amplitude scale (unsigned)
//   amp_o            amplitude scale to modulator (registered)
//   rf_enable_o      DAC/RF output enable (registered)
//   fault_latched_o  sticky fault flag
//   state_o          current FSM state
//   trip_count_o     saturating count of RAMP entries
// ---------------------------------------------------------------------------
module rf_shutdown_sequencer
   import rf_safety_pkg::*;
#(
   parameter int AMP_W            = DEF_AMP_W,
   parameter int RAMP_STEP        = DEF_RAMP_STEP,
   parameter int STEP_DIV         = DEF_STEP_DIV,
   parameter int CNT_W            = DEF_CNT_W,
   parameter int WARN_ATTEN_SHIFT = DEF_WARN_ATTEN_SHIFT
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               triggered_i,
   input  logic               warning_i,
   input  logic               rearm_i,
   input  logic [AMP_W-1:0]   amp_i,
   output logic [AMP_W-1:0]   amp_o,
   output logic               rf_enable_o,
   output logic               fault_latched_o,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   trip_count_o
);

   rf_state_e        r_state;
   rf_state_e        w_state_nxt;
   logic             r_rf_en;
   logic             w_rf_en_nxt;
   logic             r_fault;
   logic             w_fault_nxt;
   logic [CNT_W-1:0] r_trip;
   logic [CNT_W-1:0] w_trip_nxt;
   logic [CNT_W-1:0] w_trip_inc;

   logic             w_clr;
   logic             w_en;
   logic             w_dir;
   logic             w_load;
   logic [AMP_W-1:0] w_load_val;
   logic [AMP_W-1:0] w_amp;
   logic             w_step;
   logic             w_at_target;
   logic [AMP_W-1:0] w_run_amp;
   logic             w_unused;

`ifdef RF_SHUTDOWN_WARN_ATTEN_EN
   assign w_run_amp = warning_i ? (amp_i >> WARN_ATTEN_SHIFT) : amp_i;
`else
   assign w_run_amp = amp_i;
`endif

   // Signals not needed in every build are folded here.
   assign w_unused = ^{warning_i, w_step, (WARN_ATTEN_SHIFT != 0)};

   assign w_trip_inc = (r_trip == '1) ? r_trip : r_trip + 1'b1;

   ramp_stepper #(
      .AMP_W     (AMP_W),
      .RAMP_STEP (RAMP_STEP),
      .STEP_DIV  (STEP_DIV)
   ) u_stepper (
      .clk         (clk),
      .rstn        (rstn),
      .i_clr       (w_clr),
      .i_en        (w_en),
      .i_dir       (w_dir),
      .i_load      (w_load),
      .i_load_val  (w_load_val),
      .i_target    (amp_i),
      .o_value     (w_amp),
      .o_step      (w_step),
      .o_at_target (w_at_target)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_RECOVER;
         r_rf_en <= 1'b0;
         r_fault <= 1'b0;
         r_trip  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rf_en <= w_rf_en_nxt;
         r_fault <= w_fault_nxt;
         r_trip  <= w_trip_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rf_en_nxt = r_rf_en;
      w_fault_nxt = r_fault;
      w_trip_nxt  = r_trip;
      w_clr       = 1'b0;
      w_en        = 1'b0;
      w_dir       = 1'b0;
      w_load      = 1'b0;
      w_load_val  = w_amp;

      unique case (r_state)
         ST_RUN: begin
            w_rf_en_nxt = 1'b1;
            if (triggered_i) begin
               // Amplitude holds on the trip edge; the ramp starts from here.
               w_state_nxt = ST_RAMP;
               w_fault_nxt = 1'b1;
               w_trip_nxt  = w_trip_inc;
               w_clr       = 1'b1;
            end else begin
               w_load     = 1'b1;
               w_load_val = w_run_amp;
            end
         end

         ST_RAMP: begin
            w_dir = 1'b0;
            if (w_at_target) begin
               w_state_nxt = ST_SAFE;
               w_rf_en_nxt = 1'b0;
            end else begin
               w_en = 1'b1;
            end
         end

         ST_SAFE: begin
            w_rf_en_nxt = 1'b0;
            w_load      = 1'b1;
            w_load_val  = '0;
            if (rearm_i && !triggered_i) begin
               w_state_nxt = ST_RECOVER;
               w_fault_nxt = 1'b0;
               w_rf_en_nxt = 1'b1;
               w_clr       = 1'b1;
            end
         end

         ST_RECOVER: begin
            w_rf_en_nxt = 1'b1;
            w_dir       = 1'b1;
            if (triggered_i) begin
               w_state_nxt = ST_RAMP;
               w_fault_nxt = 1'b1;
               w_trip_nxt  = w_trip_inc;
               w_clr       = 1'b1;
            end else if (w_at_target) begin
               // Covers both reaching the target and amp_i dropping below.
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
               w_load_val  = amp_i;
            end else begin
               w_en = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_RECOVER;
         end
      endcase
   end

   assign amp_o           = w_amp;
   assign rf_enable_o     = r_rf_en;
   assign fault_latched_o = r_fault;
   assign state_o         = r_state;
   assign trip_count_o    = r_trip;

endmodule

// File: tb/tb_rf_shutdown_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rf_shutdown_sequencer
// Directed stimulus against rf_shutdown_sequencer (RAMP_STEP=256,
// STEP_DIV=4, CNT_W=2). A cycle-level reference model derived from the
// behavioural rules predicts every output; hand-computed literals pin key
// points of the sequence.
// ---------------------------------------------------------------------------
module tb_rf_shutdown_sequencer;

   localparam int AMP_W = 16;
   localparam int STEP  = 256;
   localparam int DIV   = 4;
   localparam int CNT_W = 2;
   localparam int TRIP_MAX = 3;

   localparam int P_RUN = 0;
   localparam int P_RAMP = 1;
   localparam int P_SAFE = 2;
   localparam int P_RECOVER = 3;

   logic             clk;
   logic             rstn;
   logic             triggered_i;
   logic             warning_i;
   logic             rearm_i;
   logic [AMP_W-1:0] amp_i;
   logic [AMP_W-1:0] amp_o;
   logic             rf_enable_o;
   logic             fault_latched_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] trip_count_o;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_phase = P_RECOVER;
   int m_amp   = 0;
   int m_en    = 0;
   int m_fault = 0;
   int m_trips = 0;
   int m_t     = 0;

   rf_shutdown_sequencer #(
      .AMP_W            (AMP_W),
      .RAMP_STEP        (STEP),
      .STEP_DIV         (DIV),
      .CNT_W            (CNT_W),
      .WARN_ATTEN_SHIFT (1)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .triggered_i     (triggered_i),
      .warning_i       (warning_i),
      .rearm_i         (rearm_i),
      .amp_i           (amp_i),
      .amp_o           (amp_o),
      .rf_enable_o     (rf_enable_o),
      .fault_latched_o (fault_latched_o),
      .state_o         (state_o),
      .trip_count_o    (trip_count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "timeout");
   end

   // Behavioural model: one update per clock edge from the inputs seen there.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_phase = P_RECOVER;
         m_amp   = 0;
         m_en    = 0;
         m_fault = 0;
         m_trips = 0;
         m_t     = 0;
      end else begin
         case (m_phase)
            P_RUN: begin
               m_en = 1;
               if (triggered_i) begin
                  m_phase = P_RAMP;
                  m_fault = 1;
                  m_trips = (m_trips < TRIP_MAX) ? m_trips + 1 : TRIP_MAX;
                  m_t     = 0;
               end else begin
`ifdef RF_SHUTDOWN_WARN_ATTEN_EN
                  m_amp = warning_i ? int'(amp_i) / 2 : int'(amp_i);
`else
                  m_amp = int'(amp_i);
`endif
               end
            end
            P_RAMP: begin
               if (m_amp == 0) begin
                  m_phase = P_SAFE;
                  m_en    = 0;
               end else begin
                  m_t = m_t + 1;
                  if (m_t % DIV == 0) m_amp = (m_amp > STEP) ? m_amp - STEP : 0;
               end
            end
            P_SAFE: begin
               m_amp = 0;
               m_en  = 0;
               if (rearm_i && !triggered_i) begin
                  m_phase = P_RECOVER;
                  m_fault = 0;
                  m_en    = 1;
                  m_t     = 0;
               end
            end
            default: begin
               m_en = 1;
               if (triggered_i) begin
                  m_phase = P_RAMP;
                  m_fault = 1;
                  m_trips = (m_trips < TRIP_MAX) ? m_trips + 1 : TRIP_MAX;
                  m_t     = 0;
               end else if (m_amp >= int'(amp_i)) begin
                  m_phase = P_RUN;
                  m_amp   = int'(amp_i);
               end else begin
                  m_t = m_t + 1;
                  if (m_t % DIV == 0)
                     m_amp = (m_amp + STEP < int'(amp_i)) ? m_amp + STEP : int'(amp_i);
               end
            end
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // One clock: wait for the falling edge and compare every output to the model.
   task automatic cyc();
      @(negedge clk);
      chk("amp_o",           32'(amp_o),           m_amp);
      chk("rf_enable_o",     32'(rf_enable_o),     m_en);
      chk("fault_latched_o", 32'(fault_latched_o), m_fault);
      chk("state_o",         32'(state_o),         m_phase);
      chk("trip_count_o",    32'(trip_count_o),    m_trips);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      rstn        = 1'b1;
      triggered_i = 1'b0;
      warning_i   = 1'b0;
      rearm_i     = 1'b0;
      amp_i       = 16'd1024;
      #1 rstn = 1'b0;
      run(2);
      chk("lit_reset_amp", 32'(amp_o), 0);
      chk("lit_reset_en", 32'(rf_enable_o), 0);
      chk("lit_reset_state", 32'(state_o), P_RECOVER);
      chk("lit_reset_trip", 32'(trip_count_o), 0);

      // soft start to 1024
      rstn = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         cyc();
         if (k == 1) chk("lit_start_en_c1", 32'(rf_enable_o), 1);
         if (k % 4 == 0 && k <= 16) chk("lit_start_amp", 32'(amp_o), 32'(256 * (k / 4)));
         if (k == 16) chk("lit_start_state_c16", 32'(state_o), P_RECOVER);
         if (k == 17) chk("lit_start_state_c17", 32'(state_o), P_RUN);
      end

      // RUN tracking with one cycle latency
      amp_i = 16'd2000;
      cyc();
      chk("lit_run_track", 32'(amp_o), 2000);
      warning_i = 1'b1;
      amp_i     = 16'd1000;
      cyc();
`ifdef RF_SHUTDOWN_WARN_ATTEN_EN
      chk("lit_warn_amp", 32'(amp_o), 500);
`else
      chk("lit_warn_amp", 32'(amp_o), 1000);
`endif
      warning_i = 1'b0;
      amp_i     = 16'd1024;
      cyc();

      // trip from RUN at 1024
      triggered_i = 1'b1;
      cyc();
      chk("lit_trip1_state", 32'(state_o), P_RAMP);
      chk("lit_trip1_fault", 32'(fault_latched_o), 1);
      chk("lit_trip1_count", 32'(trip_count_o), 1);
      chk("lit_trip1_amp", 32'(amp_o), 1024);
      triggered_i = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         amp_i = 16'(5000 + 37 * k);
         cyc();
         if (k == 4) chk("lit_ramp_amp_c4", 32'(amp_o), 768);
         if (k == 16) chk("lit_ramp_amp_c16", 32'(amp_o), 0);
         if (k == 17) chk("lit_ramp_safe_state", 32'(state_o), P_SAFE);
         if (k == 17) chk("lit_ramp_safe_en", 32'(rf_enable_o), 0);
      end

      // rearm while triggered is ignored
      triggered_i = 1'b1;
      rearm_i     = 1'b1;
      cyc();
      rearm_i = 1'b0;
      cyc();
      chk("lit_blocked_state", 32'(state_o), P_SAFE);
      chk("lit_blocked_fault", 32'(fault_latched_o), 1);
      triggered_i = 1'b0;
      cyc();
      rearm_i = 1'b1;
      amp_i   = 16'd1024;
      cyc();
      chk("lit_rearm_state", 32'(state_o), P_RECOVER);
      chk("lit_rearm_fault", 32'(fault_latched_o), 0);
      chk("lit_rearm_en", 32'(rf_enable_o), 1);
      rearm_i = 1'b0;
      run(8);
      chk("lit_recover_amp", 32'(amp_o), 512);

      // trip during RECOVER from 512
      triggered_i = 1'b1;
      cyc();
      chk("lit_trip2_state", 32'(state_o), P_RAMP);
      chk("lit_trip2_count", 32'(trip_count_o), 2);
      chk("lit_trip2_amp", 32'(amp_o), 512);
      triggered_i = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         if (k == 8) chk("lit_trip2_amp_c8", 32'(amp_o), 0);
         if (k == 9) chk("lit_trip2_safe", 32'(state_o), P_SAFE);
      end

      // trips from amplitude zero, counter saturation
      for (int n = 0; n < 3; n++) begin
         rearm_i = 1'b1;
         cyc();
         rearm_i     = 1'b0;
         triggered_i = 1'b1;
         cyc();
         chk("lit_zero_trip_ramp", 32'(state_o), P_RAMP);
         triggered_i = 1'b0;
         cyc();
         chk("lit_zero_trip_safe", 32'(state_o), P_SAFE);
      end
      chk("lit_trip_saturated", 32'(trip_count_o), 3);

      // clamped single step to 100
      amp_i   = 16'd100;
      rearm_i = 1'b1;
      cyc();
      rearm_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         if (k == 4) chk("lit_clamp_amp", 32'(amp_o), 100);
         if (k == 5) chk("lit_clamp_run", 32'(state_o), P_RUN);
      end
      triggered_i = 1'b1;
      cyc();
      triggered_i = 1'b0;
      run(5);
      chk("lit_small_ramp_safe", 32'(state_o), P_SAFE);

      // full-scale recovery, no wrap at the top
      amp_i   = 16'hFFFF;
      rearm_i = 1'b1;
      cyc();
      rearm_i = 1'b0;
      for (int k = 1; k <= 1025; k++) begin
         cyc();
         if (k == 1020) chk("lit_full_amp_ff00", 32'(amp_o), 32'h0000FF00);
         if (k == 1024) chk("lit_full_amp_ffff", 32'(amp_o), 32'h0000FFFF);
         if (k == 1025) chk("lit_full_run", 32'(state_o), P_RUN);
      end

      // asynchronous reset in the middle of a ramp
      triggered_i = 1'b1;
      cyc();
      triggered_i = 1'b0;
      run(6);
      chk("lit_midramp_amp", 32'(amp_o), 32'h0000FEFF);
      #2 rstn = 1'b0;
      #1;
      chk("lit_async_amp", 32'(amp_o), 0);
      chk("lit_async_en", 32'(rf_enable_o), 0);
      chk("lit_async_fault", 32'(fault_latched_o), 0);
      chk("lit_async_state", 32'(state_o), P_RECOVER);
      chk("lit_async_trip", 32'(trip_count_o), 0);
      cyc();
      rstn  = 1'b1;
      amp_i = 16'd300;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         if (k == 4) chk("lit_restart_amp_c4", 32'(amp_o), 256);
         if (k == 8) chk("lit_restart_amp_c8", 32'(amp_o), 300);
         if (k == 9) chk("lit_restart_run", 32'(state_o), P_RUN);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
